// File: rtl/sw_debounce_if.sv
// rtl/sw_debounce_if.sv - switch input / conditioned output bundle for sw_debounce
interface sw_debounce_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0] sw_in;
    logic [NCH-1:0] level;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
    logic [NCH-1:0] tgl;

    modport master (output sw_in, input level, input rise, input fall, input tgl);
    modport slave  (input sw_in, output level, output rise, output fall, output tgl);
endinterface

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - multi-channel switch synchronizer/debouncer (optional SW_DEBOUNCE_TOGGLE_EN latch)
module sw_debounce #(
    parameter int NCH     = 4,
    parameter int DEB_CNT = 1250000,
    parameter int CNT_W   = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    sw_debounce_if.slave bus
);
    // State bit 1 doubles as the debounced level, so level comes straight off a flop.
    localparam logic [1:0] ST_LOW      = 2'b00;
    localparam logic [1:0] ST_LOW_CHK  = 2'b01;
    localparam logic [1:0] ST_HIGH     = 2'b10;
    localparam logic [1:0] ST_HIGH_CHK = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NCH-1:0]            s1_q, s1_d;
    logic [NCH-1:0]            s_q, s_d;
    logic [NCH-1:0]            rise_q, rise_d;
    logic [NCH-1:0]            fall_q, fall_d;
    logic [NCH-1:0][1:0]       state_q, state_d;
    logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]            level_w;

    // Two-flop synchronizer from the pads into clk.
    always_comb begin
        s1_d = bus.sw_in;
        s_d  = s1_q;
    end

    // Per-channel debounce FSM: count consecutive samples that disagree with the level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < NCH; i++) begin
            case (state_q[i])
                ST_LOW: begin
                    if (s_q[i]) begin
                        if (DEB_CNT == 1) begin
                            state_d[i] = ST_HIGH;
                            cnt_d[i]   = '0;
                            rise_d[i]  = 1'b1;
                        end else begin
                            state_d[i] = ST_LOW_CHK;
                            cnt_d[i]   = CNT_ONE;
                        end
                    end
                end
                ST_LOW_CHK: begin
                    if (!s_q[i]) begin
                        state_d[i] = ST_LOW;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_HIGH;
                        cnt_d[i]   = '0;
                        rise_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!s_q[i]) begin
                        if (DEB_CNT == 1) begin
                            state_d[i] = ST_LOW;
                            cnt_d[i]   = '0;
                            fall_d[i]  = 1'b1;
                        end else begin
                            state_d[i] = ST_HIGH_CHK;
                            cnt_d[i]   = CNT_ONE;
                        end
                    end
                end
                default: begin
                    if (s_q[i]) begin
                        state_d[i] = ST_HIGH;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_LOW;
                        cnt_d[i]   = '0;
                        fall_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // State, counter, synchronizer and strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s_q     <= '0;
            state_q <= '0;
            cnt_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            s1_q    <= s1_d;
            s_q     <= s_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Level is the high-half indicator of each channel's state.
    always_comb begin
        level_w = '0;
        for (int i = 0; i < NCH; i++) begin
            level_w[i] = state_q[i][1];
        end
    end

    assign bus.level = level_w;
    assign bus.rise  = rise_q;
    assign bus.fall  = fall_q;

`ifdef SW_DEBOUNCE_TOGGLE_EN
    logic [NCH-1:0] tgl_q, tgl_d;

    // Push-on/push-off latch flips on the edge that raises rise.
    always_comb begin
        tgl_d = tgl_q ^ rise_d;
    end

    // Toggle latch register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgl_q <= '0;
        end else begin
            tgl_q <= tgl_d;
        end
    end

    assign bus.tgl = tgl_q;
`else
    assign bus.tgl = '0;
`endif
endmodule
